// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32I fetch path.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} fetch_state_t;
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_id_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory and IF/ID handshake bundle around the fetch stage.
interface fetch_unit_if #(parameter int ADDR_W = 5);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_instr;
  logic if_valid;
  logic id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  modport master (output imem_addr, if_valid, if_instr, if_pc, input imem_instr, id_ready);
  modport slave (input imem_addr, if_valid, if_instr, if_pc, output imem_instr, id_ready);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush or drain inserts a bubble, load captures a fetch.
module if_id_reg import core_pkg::*; #(
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic load,
  input  logic clear,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  output if_id_t q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '{valid: 1'b0, instr: NOP, pc: '0};
    else if (flush || clear) begin
      q.valid <= 1'b0;
      q.instr <= NOP;
    end else if (load) q <= '{valid: 1'b1, instr: d_instr, pc: d_pc};
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage holding the PC, redirect/halt control and the IF/ID register.
module fetch_unit import core_pkg::*; #(
  parameter int ADDR_W = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic clk,
  input  logic rst_n,
  input  logic halt,
  input  logic redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic fetch_misalign,
  fetch_unit_if.master bus
);
  fetch_state_t state;
  if_id_t r;
  logic load, clear;
  // halt does not block a capture already due in S_RUN; it only moves the FSM to S_HALT
  assign load = state == S_RUN && (!r.valid || bus.id_ready) && !redirect_valid;
  assign clear = state == S_HALT && r.valid && bus.id_ready;
  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk(clk), .rst_n(rst_n), .flush(redirect_valid), .load(load), .clear(clear),
    .d_instr(bus.imem_instr), .d_pc(pc), .q(r)
  );
  assign bus.imem_addr = pc[ADDR_W+1:2];
  assign bus.if_valid = r.valid;
  assign bus.if_instr = r.instr;
  assign bus.if_pc = r.pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_BOOT;
      pc <= RESET_PC;
      fetch_misalign <= 1'b0;
    end else begin
      state <= halt ? S_HALT : S_RUN;
      pc <= redirect_valid ? {redirect_target[31:2], 2'b00} : load ? pc + 32'd4 : pc;
      fetch_misalign <= redirect_valid && |redirect_target[1:0];
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of boot, stall, redirect, misalign, halt, wrap and async reset.
module tb_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0, halt = 1'b0, redirect_valid = 1'b0, fetch_misalign;
  logic [31:0] redirect_target = '0, pc;
  logic [31:0] mem [32];
  int vec = 0, errs = 0;
  fetch_unit_if #(.ADDR_W(5)) bus ();
  fetch_unit #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .pc(pc), .fetch_misalign(fetch_misalign), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.imem_instr = mem[bus.imem_addr];

  task automatic test_reset();
    bus.id_ready = 1'b1;
    repeat (2) @(negedge clk);
    vec++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b exp 0", bus.if_valid); end
    vec++; if (bus.if_instr !== 32'h13) begin errs++; $display("FAIL rst_instr got %h exp 00000013", bus.if_instr); end
    vec++; if (bus.if_pc !== 32'h0) begin errs++; $display("FAIL rst_if_pc got %h exp 0", bus.if_pc); end
    vec++; if (pc !== 32'h0) begin errs++; $display("FAIL rst_pc got %h exp 0", pc); end
    vec++; if (fetch_misalign !== 1'b0) begin errs++; $display("FAIL rst_misalign got %b exp 0", fetch_misalign); end
    vec++; if (bus.imem_addr !== 5'd0) begin errs++; $display("FAIL rst_addr got %0d exp 0", bus.imem_addr); end
  endtask

  task automatic test_boot_run();
    rst_n = 1'b1;
    @(negedge clk);
    vec++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL boot_valid got %b exp 0", bus.if_valid); end
    vec++; if (pc !== 32'h0) begin errs++; $display("FAIL boot_pc got %h exp 0", pc); end
    @(negedge clk);
    vec++; if (bus.if_valid !== 1'b1) begin errs++; $display("FAIL run0_valid got %b exp 1", bus.if_valid); end
    vec++; if (bus.if_instr !== 32'h003000B3) begin errs++; $display("FAIL run0_instr got %h exp 003000b3", bus.if_instr); end
    vec++; if (bus.if_pc !== 32'h0) begin errs++; $display("FAIL run0_pc got %h exp 0", bus.if_pc); end
    @(negedge clk);
    vec++; if (bus.if_instr !== 32'h015A0933) begin errs++; $display("FAIL run1_instr got %h exp 015a0933", bus.if_instr); end
    vec++; if (bus.if_pc !== 32'h4) begin errs++; $display("FAIL run1_if_pc got %h exp 4", bus.if_pc); end
    vec++; if (pc !== 32'h8) begin errs++; $display("FAIL run1_pc got %h exp 8", pc); end
  endtask

  task automatic test_stall();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++; if (bus.if_instr !== 32'h015A0933) begin errs++; $display("FAIL stall%0d_instr got %h exp 015a0933", i, bus.if_instr); end
      vec++; if (bus.if_pc !== 32'h4) begin errs++; $display("FAIL stall%0d_if_pc got %h exp 4", i, bus.if_pc); end
      vec++; if (pc !== 32'h8) begin errs++; $display("FAIL stall%0d_pc got %h exp 8", i, pc); end
      vec++; if (bus.if_valid !== 1'b1) begin errs++; $display("FAIL stall%0d_valid got %b exp 1", i, bus.if_valid); end
    end
    bus.id_ready = 1'b1;
    @(negedge clk);
    vec++; if (bus.if_pc !== 32'h8) begin errs++; $display("FAIL unstall_if_pc got %h exp 8", bus.if_pc); end
    vec++; if (bus.if_instr !== 32'h3) begin errs++; $display("FAIL unstall_instr got %h exp 3", bus.if_instr); end
    vec++; if (pc !== 32'hC) begin errs++; $display("FAIL unstall_pc got %h exp c", pc); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_target = 32'h1C;
    @(negedge clk);
    redirect_valid = 1'b0;
    vec++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL redir_valid got %b exp 0", bus.if_valid); end
    vec++; if (bus.if_instr !== 32'h13) begin errs++; $display("FAIL redir_instr got %h exp 00000013", bus.if_instr); end
    vec++; if (pc !== 32'h1C) begin errs++; $display("FAIL redir_pc got %h exp 1c", pc); end
    vec++; if (bus.imem_addr !== 5'd7) begin errs++; $display("FAIL redir_addr got %0d exp 7", bus.imem_addr); end
    vec++; if (fetch_misalign !== 1'b0) begin errs++; $display("FAIL redir_misalign got %b exp 0", fetch_misalign); end
    @(negedge clk);
    vec++; if (bus.if_instr !== 32'h8) begin errs++; $display("FAIL redir_next_instr got %h exp 8", bus.if_instr); end
    vec++; if (bus.if_pc !== 32'h1C) begin errs++; $display("FAIL redir_next_if_pc got %h exp 1c", bus.if_pc); end
    vec++; if (pc !== 32'h20) begin errs++; $display("FAIL redir_next_pc got %h exp 20", pc); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_target = 32'h16;
    @(negedge clk);
    redirect_valid = 1'b0;
    vec++; if (fetch_misalign !== 1'b1) begin errs++; $display("FAIL mis_flag got %b exp 1", fetch_misalign); end
    vec++; if (pc !== 32'h14) begin errs++; $display("FAIL mis_pc got %h exp 14", pc); end
    vec++; if (bus.imem_addr !== 5'd5) begin errs++; $display("FAIL mis_addr got %0d exp 5", bus.imem_addr); end
    vec++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL mis_valid got %b exp 0", bus.if_valid); end
    @(negedge clk);
    vec++; if (fetch_misalign !== 1'b0) begin errs++; $display("FAIL mis_pulse got %b exp 0", fetch_misalign); end
    vec++; if (bus.if_instr !== 32'h6) begin errs++; $display("FAIL mis_instr got %h exp 6", bus.if_instr); end
    vec++; if (bus.if_pc !== 32'h14) begin errs++; $display("FAIL mis_if_pc got %h exp 14", bus.if_pc); end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    @(negedge clk);
    vec++; if (bus.if_instr !== 32'h7) begin errs++; $display("FAIL halt_cap_instr got %h exp 7", bus.if_instr); end
    vec++; if (bus.if_pc !== 32'h18) begin errs++; $display("FAIL halt_cap_if_pc got %h exp 18", bus.if_pc); end
    vec++; if (pc !== 32'h1C) begin errs++; $display("FAIL halt_cap_pc got %h exp 1c", pc); end
    @(negedge clk);
    vec++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL halt_drain_valid got %b exp 0", bus.if_valid); end
    vec++; if (bus.if_instr !== 32'h13) begin errs++; $display("FAIL halt_drain_instr got %h exp 00000013", bus.if_instr); end
    @(negedge clk);
    vec++; if (pc !== 32'h1C) begin errs++; $display("FAIL halt_frozen_pc got %h exp 1c", pc); end
    vec++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL halt_frozen_valid got %b exp 0", bus.if_valid); end
    halt = 1'b0;
    @(negedge clk);
    vec++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL resume_gap_valid got %b exp 0", bus.if_valid); end
    vec++; if (pc !== 32'h1C) begin errs++; $display("FAIL resume_gap_pc got %h exp 1c", pc); end
    @(negedge clk);
    vec++; if (bus.if_instr !== 32'h8) begin errs++; $display("FAIL resume_instr got %h exp 8", bus.if_instr); end
    vec++; if (bus.if_pc !== 32'h1C) begin errs++; $display("FAIL resume_if_pc got %h exp 1c", bus.if_pc); end
    vec++; if (pc !== 32'h20) begin errs++; $display("FAIL resume_pc got %h exp 20", pc); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 32'h7C;
    @(negedge clk);
    redirect_valid = 1'b0;
    vec++; if (bus.imem_addr !== 5'd31) begin errs++; $display("FAIL wrap_addr31 got %0d exp 31", bus.imem_addr); end
    @(negedge clk);
    vec++; if (bus.if_instr !== 32'h20) begin errs++; $display("FAIL wrap_w31_instr got %h exp 20", bus.if_instr); end
    vec++; if (bus.if_pc !== 32'h7C) begin errs++; $display("FAIL wrap_w31_if_pc got %h exp 7c", bus.if_pc); end
    vec++; if (pc !== 32'h80) begin errs++; $display("FAIL wrap_pc got %h exp 80", pc); end
    vec++; if (bus.imem_addr !== 5'd0) begin errs++; $display("FAIL wrap_addr0 got %0d exp 0", bus.imem_addr); end
    @(negedge clk);
    vec++; if (bus.if_instr !== 32'h003000B3) begin errs++; $display("FAIL wrap_w0_instr got %h exp 003000b3", bus.if_instr); end
    vec++; if (bus.if_pc !== 32'h80) begin errs++; $display("FAIL wrap_w0_if_pc got %h exp 80", bus.if_pc); end
  endtask

  task automatic test_async_reset();
    bus.id_ready = 1'b0;
    @(negedge clk);
    vec++; if (bus.if_valid !== 1'b1) begin errs++; $display("FAIL pre_rst_valid got %b exp 1", bus.if_valid); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL async_valid got %b exp 0", bus.if_valid); end
    vec++; if (pc !== 32'h0) begin errs++; $display("FAIL async_pc got %h exp 0", pc); end
    vec++; if (bus.if_instr !== 32'h13) begin errs++; $display("FAIL async_instr got %h exp 00000013", bus.if_instr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'(i + 1);
    mem[0] = 32'h003000B3;
    mem[1] = 32'h015A0933;
    test_reset();
    test_boot_run();
    test_stall();
    test_redirect();
    test_misalign();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
